alu_ctrl_pipe: RTL and testbench

- Registered ALU-control stage for the 5-stage MIPS pipeline, sitting on the ID/EX boundary.
- Decodes {alu_opcode, func} into a widened ALU control code.
- Latches the code into EX with stall/flush support.
- Sequences multi-cycle mult/div ops: holds off ID until the operation completes.

---
 rtl/alu_ctrl_pkg.sv | 35 +++
 rtl/alu_ctrl_pipe_if.sv | 36 +++
 rtl/alu_ctrl_decode.sv | 48 ++++
 rtl/alu_ctrl_pipe.sv | 155 +++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ID/EX ALU-control stage: ALU codes, R-type funct values, mult/div FSM states.
package alu_ctrl_pkg;

  localparam int unsigned PERF_MD_W  = 32;
  localparam int unsigned PERF_ILL_W = 16;

  typedef enum logic [3:0] {
    ALU_ILL  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_LUI  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_JR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_MULT = 4'd8,
    ALU_DIV  = 4'd9
  } alu_code_e;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// ID/EX boundary bundle for the ALU-control stage; master is the pipeline side, slave the stage.
interface alu_ctrl_pipe_if
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned FUNC_W = 6,
  parameter int unsigned CTRL_W = 4
);

  logic                  id_valid;
  logic [OPC_W-1:0]      id_opcode;
  logic [FUNC_W-1:0]     id_func;
  logic                  id_ready;
  logic                  ex_stall;
  logic                  flush;
  logic                  ex_valid;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic                  ex_illegal;
  logic                  md_busy;
  logic                  md_done;
  logic [PERF_MD_W-1:0]  perf_md_stall;
  logic [PERF_ILL_W-1:0] perf_illegal;

  modport master (
    output id_valid, id_opcode, id_func, ex_stall, flush,
    input  id_ready, ex_valid, ex_ctrl, ex_illegal, md_busy, md_done,
           perf_md_stall, perf_illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_func, ex_stall, flush,
    output id_ready, ex_valid, ex_ctrl, ex_illegal, md_busy, md_done,
           perf_md_stall, perf_illegal
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational {opcode, funct} -> ALU control table; unknown encodings give code 0 with illegal set.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned FUNC_W = 6,
  parameter int unsigned CTRL_W = 4
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal,
  output logic              is_md
);

  alu_code_e code;

  // Opcode 0 is R-type and is resolved by funct; everything else by opcode alone.
  always_comb begin
    code    = ALU_ILL;
    illegal = 1'b0;
    if (opcode == '0) begin
      case (func)
        FUNC_W'(F_ADDU): code = ALU_ADD;
        FUNC_W'(F_SUBU): code = ALU_SUB;
        FUNC_W'(F_JR):   code = ALU_JR;
        FUNC_W'(F_AND):  code = ALU_AND;
        FUNC_W'(F_OR):   code = ALU_OR;
        FUNC_W'(F_SLT):  code = ALU_SLT;
        FUNC_W'(F_MULT): code = ALU_MULT;
        FUNC_W'(F_DIV):  code = ALU_DIV;
        default:         illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OPC_W'(1): code = ALU_ADD;
        OPC_W'(2): code = ALU_SUB;
        OPC_W'(3): code = ALU_LUI;
        OPC_W'(4): code = ALU_OR;
        default:   illegal = 1'b1;
      endcase
    end
  end

  assign ctrl  = CTRL_W'(code);
  assign is_md = (code == ALU_MULT) || (code == ALU_DIV);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU-control stage on the ID/EX boundary with stall/flush and a mult/div occupancy FSM.
// Optional performance counters are built when ALU_CTRL_PERF_EN is defined.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W      = 4,
  parameter int unsigned FUNC_W     = 6,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ctrl_pipe_if.slave   bus
);

  localparam int unsigned CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              dec_is_md;

  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic              md_busy_q;
  logic              md_done_q;

  logic              ex_valid_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic              ex_illegal_q;

  logic              ready_c;
  logic              capture_c;
  logic              md_start_c;

  alu_ctrl_decode #(
    .OPC_W  (OPC_W),
    .FUNC_W (FUNC_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .opcode  (bus.id_opcode),
    .func    (bus.id_func),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_md   (dec_is_md)
  );

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign ready_c    = rst_n && !bus.ex_stall && ((state == MD_IDLE) || (state == MD_DONE));
  assign capture_c  = bus.id_valid && ready_c && !bus.flush;
  assign md_start_c = capture_c && dec_is_md && !dec_illegal;

  // EX pipeline registers: flush beats capture, capture beats hold/bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_illegal_q <= 1'b0;
    end else if (bus.flush) begin
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else if (capture_c) begin
      ex_valid_q   <= 1'b1;
      ex_ctrl_q    <= dec_ctrl;
      ex_illegal_q <= dec_illegal;
    end else if (!bus.ex_stall && (state != MD_BUSY)) begin
      ex_valid_q   <= 1'b0;
    end
  end

  // Mult/div sequencer; BUSY lasts MULDIV_LAT-1 cycles and ignores ex_stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else if (bus.flush) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start_c) begin
            state     <= MD_BUSY;
            cnt       <= CNT_W'(MULDIV_LAT - 2);
            md_busy_q <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            state     <= MD_DONE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MD_DONE: begin
          if (!bus.ex_stall) begin
            md_done_q <= 1'b0;
            if (md_start_c) begin
              state     <= MD_BUSY;
              cnt       <= CNT_W'(MULDIV_LAT - 2);
              md_busy_q <= 1'b1;
            end else begin
              state <= MD_IDLE;
            end
          end
        end
        default: begin
          state     <= MD_IDLE;
          cnt       <= '0;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.id_ready   = ready_c;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_illegal = ex_illegal_q;
  assign bus.md_busy    = md_busy_q;
  assign bus.md_done    = md_done_q;

`ifdef ALU_CTRL_PERF_EN
  logic [PERF_MD_W-1:0]  perf_md_q;
  logic [PERF_ILL_W-1:0] perf_ill_q;

  // Stall cycles wrap; illegal count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_md_q  <= '0;
      perf_ill_q <= '0;
    end else begin
      if (bus.id_valid && (state == MD_BUSY)) begin
        perf_md_q <= perf_md_q + PERF_MD_W'(1);
      end
      if (capture_c && dec_illegal && (perf_ill_q != '1)) begin
        perf_ill_q <= perf_ill_q + PERF_ILL_W'(1);
      end
    end
  end

  assign bus.perf_md_stall = perf_md_q;
  assign bus.perf_illegal  = perf_ill_q;
`else
  assign bus.perf_md_stall = '0;
  assign bus.perf_illegal  = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: decode table, directed mult/div/flush/stall/reset
// sequences and a randomized run against a cycle-occupancy reference model.
module tb_alu_ctrl_pipe;
  import alu_ctrl_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_ctrl_pipe_if #(.OPC_W(4), .FUNC_W(6), .CTRL_W(4)) bus ();

  alu_ctrl_pipe #(.OPC_W(4), .FUNC_W(6), .CTRL_W(4), .MULDIV_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction table.
  logic [5:0] r_funct [8] = '{6'b100001, 6'b100011, 6'b001000, 6'b100100,
                              6'b100101, 6'b101010, 6'b011000, 6'b011010};
  logic [3:0] r_code  [8] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd4, 4'd7, 4'd8, 4'd9};

  function automatic void ref_decode(input logic [3:0] opc, input logic [5:0] fn,
                                     output logic [3:0] code, output logic ill);
    code = 4'd0;
    ill  = 1'b1;
    if (opc == 4'd0) begin
      for (int i = 0; i < 8; i++) begin
        if (r_funct[i] == fn) begin
          code = r_code[i];
          ill  = 1'b0;
        end
      end
    end else if (opc >= 4'd1 && opc <= 4'd4) begin
      code = opc;
      ill  = 1'b0;
    end
  endfunction

  // Model: m_age counts cycles since an md op was captured (-1 = none).
  logic        m_valid = 1'b0;
  logic        m_ill   = 1'b0;
  logic [3:0]  m_ctrl  = 4'd0;
  int          m_age   = -1;
  logic [31:0] m_pmd   = 32'd0;
  logic [15:0] m_pill  = 16'd0;

  function automatic logic m_busy();
    return (m_age >= 1) && (m_age < LAT);
  endfunction

  function automatic logic m_done();
    return m_age >= LAT;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] code;
    logic       ill, busy, done, cap;
    if (!rst_n) begin
      m_valid = 1'b0; m_ill = 1'b0; m_ctrl = 4'd0; m_age = -1;
      m_pmd = 32'd0; m_pill = 16'd0;
    end else begin
      busy = m_busy();
      done = m_done();
      ref_decode(bus.id_opcode, bus.id_func, code, ill);
      cap  = bus.id_valid && !bus.ex_stall && !busy && !bus.flush;
      if (bus.id_valid && busy) m_pmd = m_pmd + 32'd1;
      if (cap && ill && m_pill != 16'hFFFF) m_pill = m_pill + 16'd1;
      if (bus.flush) begin
        m_valid = 1'b0; m_ill = 1'b0; m_age = -1;
      end else if (cap) begin
        m_valid = 1'b1; m_ctrl = code; m_ill = ill;
        m_age   = (code == 4'd8 || code == 4'd9) ? 1 : -1;
      end else begin
        if (!bus.ex_stall && !busy) m_valid = 1'b0;
        if (busy) m_age = m_age + 1;
        else if (done && bus.ex_stall) m_age = LAT;
        else m_age = -1;
      end
    end
  end

  task automatic model_check();
    logic busy;
    busy = m_busy();
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    if (m_valid) chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(m_ctrl));
    chk("ex_illegal", 32'(bus.ex_illegal), 32'(m_ill));
    chk("md_busy", 32'(bus.md_busy), 32'(busy));
    chk("md_done", 32'(bus.md_done), 32'(m_done()));
    chk("id_ready", 32'(bus.id_ready), 32'(rst_n && !bus.ex_stall && !busy));
`ifdef ALU_CTRL_PERF_EN
    chk("perf_md_stall", bus.perf_md_stall, m_pmd);
    chk("perf_illegal", 32'(bus.perf_illegal), 32'(m_pill));
`else
    chk("perf_md_stall_off", bus.perf_md_stall, 32'd0);
    chk("perf_illegal_off", 32'(bus.perf_illegal), 32'd0);
`endif
  endtask

  task automatic tick(input logic v, input logic [3:0] o, input logic [5:0] f,
                      input logic s, input logic fl);
    @(negedge clk);
    bus.id_valid  = v;
    bus.id_opcode = o;
    bus.id_func   = f;
    bus.ex_stall  = s;
    bus.flush     = fl;
    #1;
    model_check();
  endtask

  task automatic idle();
    tick(1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!bus.id_ready && n < 10) begin
      idle();
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(bus.id_ready), 32'd1);
  endtask

  typedef struct {
    logic       v;
    logic [3:0] opc;
    logic [5:0] fn;
    logic       exp_valid;
    logic [3:0] exp_ctrl;
    logic       exp_ill;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 4'd0, 6'b100001, 1'b1, 4'd1, 1'b0};
    tbl[1]  = '{1'b1, 4'd0, 6'b101010, 1'b1, 4'd7, 1'b0};
    tbl[2]  = '{1'b1, 4'd3, 6'b000000, 1'b1, 4'd3, 1'b0};
    tbl[3]  = '{1'b1, 4'd1, 6'b111111, 1'b1, 4'd1, 1'b0};
    tbl[4]  = '{1'b1, 4'd2, 6'b000000, 1'b1, 4'd2, 1'b0};
    tbl[5]  = '{1'b1, 4'd4, 6'b011000, 1'b1, 4'd4, 1'b0};
    tbl[6]  = '{1'b1, 4'd0, 6'b100011, 1'b1, 4'd2, 1'b0};
    tbl[7]  = '{1'b1, 4'd0, 6'b001000, 1'b1, 4'd5, 1'b0};
    tbl[8]  = '{1'b1, 4'd0, 6'b100100, 1'b1, 4'd6, 1'b0};
    tbl[9]  = '{1'b1, 4'd0, 6'b100101, 1'b1, 4'd4, 1'b0};
    tbl[10] = '{1'b1, 4'd5, 6'b100001, 1'b1, 4'd0, 1'b1};
    tbl[11] = '{1'b1, 4'd15, 6'b000000, 1'b1, 4'd0, 1'b1};
    tbl[12] = '{1'b1, 4'd0, 6'b000000, 1'b1, 4'd0, 1'b1};
    tbl[13] = '{1'b1, 4'd0, 6'b011000, 1'b1, 4'd8, 1'b0};
    tbl[14] = '{1'b1, 4'd0, 6'b011010, 1'b1, 4'd9, 1'b0};
    tbl[15] = '{1'b0, 4'd0, 6'b100001, 1'b0, 4'd0, 1'b0};

    rst_n = 1'b0;
    bus.id_valid = 1'b0; bus.id_opcode = 4'd0; bus.id_func = 6'd0;
    bus.ex_stall = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("rst_id_ready", 32'(bus.id_ready), 32'd0);
    chk("rst_md", 32'({bus.md_busy, bus.md_done, bus.ex_illegal}), 32'd0);
    rst_n = 1'b1;

    // Illegal R-type funct: captured flagged, never busy.
    tick(1'b1, 4'd0, 6'b111111, 1'b0, 1'b0);
    idle();
    chk("ill_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("ill_flag", 32'(bus.ex_illegal), 32'd1);
    chk("ill_busy", 32'(bus.md_busy), 32'd0);
`ifdef ALU_CTRL_PERF_EN
    chk("ill_perf", 32'(bus.perf_illegal), 32'd1);
`endif

    // mult with id_valid held: busy cycles 1-3, done at 4, next op taken at the cycle-4 edge.
    tick(1'b1, 4'd0, F_MULT, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick(1'b1, 4'd0, F_ADDU, 1'b0, 1'b0);
      chk($sformatf("mul_busy_c%0d", c), 32'(bus.md_busy), (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("mul_done_c%0d", c), 32'(bus.md_done), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("mul_ready_c%0d", c), 32'(bus.id_ready), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("mul_ctrl_c%0d", c), 32'(bus.ex_ctrl), 32'd8);
    end
    idle();
    chk("mul_next_ctrl", 32'(bus.ex_ctrl), 32'd1);
    chk("mul_next_done", 32'(bus.md_done), 32'd0);
`ifdef ALU_CTRL_PERF_EN
    chk("mul_perf", bus.perf_md_stall, 32'd3);
`endif
    idle();

    // Decode table, one op at a time.
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].v, tbl[i].opc, tbl[i].fn, 1'b0, 1'b0);
      idle();
      chk($sformatf("tbl%0d_valid", i), 32'(bus.ex_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_ctrl", i), 32'(bus.ex_ctrl), 32'(tbl[i].exp_ctrl));
        chk($sformatf("tbl%0d_ill", i), 32'(bus.ex_illegal), 32'(tbl[i].exp_ill));
      end
      drain($sformatf("tbl%0d", i));
    end

    // div flushed two cycles after capture: no done pulse ever follows.
    tick(1'b1, 4'd0, F_DIV, 1'b0, 1'b0);
    idle();
    tick(1'b0, 4'd0, 6'd0, 1'b0, 1'b1);
    idle();
    chk("fl_valid", 32'(bus.ex_valid), 32'd0);
    chk("fl_busy", 32'(bus.md_busy), 32'd0);
    chk("fl_ready", 32'(bus.id_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      idle();
      chk($sformatf("fl_nodone%0d", c), 32'(bus.md_done), 32'd0);
    end

    // mult reaching DONE under stall: done and ctrl held until stall drops.
    tick(1'b1, 4'd0, F_MULT, 1'b0, 1'b0);
    repeat (3) idle();
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 4'd0, F_ADDU, 1'b1, 1'b0);
      chk($sformatf("st_done%0d", c), 32'(bus.md_done), 32'd1);
      chk($sformatf("st_ctrl%0d", c), 32'(bus.ex_ctrl), 32'd8);
      chk($sformatf("st_ready%0d", c), 32'(bus.id_ready), 32'd0);
    end
    tick(1'b1, 4'd0, F_ADDU, 1'b0, 1'b0);
    chk("st_done_rel", 32'(bus.md_done), 32'd1);
    chk("st_ready_rel", 32'(bus.id_ready), 32'd1);
    idle();
    chk("st_after_done", 32'(bus.md_done), 32'd0);
    chk("st_after_ctrl", 32'(bus.ex_ctrl), 32'd1);
    chk("st_after_busy", 32'(bus.md_busy), 32'd0);

    // Asynchronous reset in the middle of BUSY.
    tick(1'b1, 4'd0, F_MULT, 1'b0, 1'b0);
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.ex_valid), 32'd0);
    chk("ar_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("ar_busy", 32'(bus.md_busy), 32'd0);
    chk("ar_done", 32'(bus.md_done), 32'd0);
    chk("ar_ready", 32'(bus.id_ready), 32'd0);
    chk("ar_perf", bus.perf_md_stall | 32'(bus.perf_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 4'd0, F_ADDU, 1'b0, 1'b0);
    idle();
    chk("ar_addu_valid", 32'(bus.ex_valid), 32'd1);
    chk("ar_addu_ctrl", 32'(bus.ex_ctrl), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic       v, s, fl;
      logic [3:0] o;
      logic [5:0] f;
      v  = ($urandom_range(0, 9) < 7);
      o  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      f  = ($urandom_range(0, 3) != 0) ? r_funct[$urandom_range(0, 7)]
                                       : 6'($urandom_range(0, 63));
      s  = ($urandom_range(0, 9) < 2);
      fl = ($urandom_range(0, 29) == 0);
      tick(v, o, f, s, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
